// File: rtl/ext_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
// Mode codes for ext_core, buffer depth, and the buffer occupancy states.
package ext_pkg;

  typedef logic [2:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN     = 3'b000;
  localparam ext_mode_t EXT_ZERO     = 3'b001;
  localparam ext_mode_t EXT_UPPER    = 3'b010;
  localparam ext_mode_t EXT_SIGN_SHL = 3'b011;

  // Number of entries held by the output buffer.
  localparam int EXT_DEPTH = 2;

  // Buffer occupancy; the encoding equals the entry count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: maps an IN_W-bit immediate and a mode
// code to an OUT_W-bit value. Reserved modes yield 0.
// Optional macro EXT_ERR_EN adds o_err, set for reserved modes.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]  i_imm,
  input  ext_mode_t        i_mode,
`ifdef EXT_ERR_EN
  output logic             o_err,
`endif
  output logic [OUT_W-1:0] o_data
);

  logic [OUT_W-1:0] w_sext;

  // Size cast of a signed operand replicates the MSB, and stays legal when IN_W == OUT_W.
  assign w_sext = OUT_W'($signed(i_imm));

  // Select the extension for the current mode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_data = '0;
`ifdef EXT_ERR_EN
    o_err  = 1'b0;
`endif
    case (i_mode)
      EXT_SIGN:     o_data = w_sext;
      EXT_ZERO:     o_data = OUT_W'(i_imm);
      EXT_UPPER:    o_data = OUT_W'(i_imm) << (OUT_W - IN_W);
      EXT_SIGN_SHL: o_data = w_sext << SHAMT;
      default: begin
`ifdef EXT_ERR_EN
        o_err = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate-extension unit with a 2-entry in-order output buffer
// and valid/ready handshakes on both sides. Entry 0 is always the head.
// Optional macro EXT_ERR_EN adds out_err, carried alongside each entry.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef EXT_ERR_EN
  output logic             out_err,
`endif
  output logic [OUT_W-1:0] out_data
);

`ifdef EXT_ERR_EN
  localparam int ENTRY_W = OUT_W + 1;
`else
  localparam int ENTRY_W = OUT_W;
`endif

  logic [OUT_W-1:0]   w_data;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_push;
  logic               w_pop;

  buf_state_t         r_state;
  logic [ENTRY_W-1:0] r_entry0;
  logic [ENTRY_W-1:0] r_entry1;

`ifdef EXT_ERR_EN
  logic w_err;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) u_core (
    .i_imm  (in_imm),
    .i_mode (in_mode),
    .o_err  (w_err),
    .o_data (w_data)
  );

  assign w_entry = {w_err, w_data};
  assign out_err = r_entry0[OUT_W];
`else
  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) u_core (
    .i_imm  (in_imm),
    .i_mode (in_mode),
    .o_data (w_data)
  );

  assign w_entry = w_data;
`endif

  // Handshake flags come from registered occupancy only; out_ready never reaches in_ready.
  assign in_ready  = (r_state != buf_state_t'(EXT_DEPTH));
  assign out_valid = (r_state != BUF_EMPTY);
  assign out_data  = r_entry0[OUT_W-1:0];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Occupancy FSM and buffer storage, with synchronous flush on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the two entries are reset because the head drives out_data, which must read 0 after reset.
      r_state  <= BUF_EMPTY;
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else begin
      // NOTE: non-blocking assignments so the shift r_entry0 <= r_entry1 reads pre-edge values.
      case (r_state)
        BUF_EMPTY: begin
          if (w_push) begin
            r_entry0 <= w_entry;
            r_state  <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (w_push && w_pop) begin
            r_entry0 <= w_entry;
          end else if (w_push) begin
            r_entry1 <= w_entry;
            r_state  <= BUF_TWO;
          end else if (w_pop) begin
            r_state  <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (w_pop) begin
            r_entry0 <= r_entry1;
            r_state  <= BUF_ONE;
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe (IN_W=16, OUT_W=32, SHAMT=2).
// Builds with or without EXT_ERR_EN; out_err is checked only when defined.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef EXT_ERR_EN
  logic        out_err;
`endif

  ext_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef EXT_ERR_EN
    .out_err   (out_err),
`endif
    .out_data  (out_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension for the fixed test parameters.
  function automatic exp_t model(input logic [2:0] mode, input logic [15:0] imm);
    exp_t        e;
    logic [31:0] s;
    s     = {{16{imm[15]}}, imm};
    e.err = 1'b0;
    case (mode)
      3'b000:  e.data = s;
      3'b001:  e.data = {16'h0000, imm};
      3'b010:  e.data = {imm, 16'h0000};
      3'b011:  e.data = {s[29:0], 2'b00};
      default: begin
        e.data = 32'h0;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [2:0] mode, input logic [15:0] imm);
    in_valid = v;
    in_mode  = mode;
    in_imm   = imm;
    cur_exp  = model(mode, imm);
  endtask

  // One clock: score a pop, record a push, then advance to just after the edge.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected no output", out_data);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", out_data, e.data);
`ifdef EXT_ERR_EN
        check("sb_err", {31'b0, out_err}, {31'b0, e.err});
`endif
      end
    end
    if (in_valid && in_ready) sb_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'b000, 16'h8001, 32'hFFFF8001};
    vecs[1] = '{3'b001, 16'h8001, 32'h00008001};
    vecs[2] = '{3'b010, 16'h1234, 32'h12340000};
    vecs[3] = '{3'b011, 16'hFFFF, 32'hFFFFFFFC};
    vecs[4] = '{3'b011, 16'h4001, 32'h00010004};
    vecs[5] = '{3'b000, 16'h7FFF, 32'h00007FFF};
    vecs[6] = '{3'b011, 16'h8000, 32'hFFFE0000};
    vecs[7] = '{3'b101, 16'hABCD, 32'h00000000};
    vecs[8] = '{3'b111, 16'hFFFF, 32'h00000000};
    vecs[9] = '{3'b010, 16'hFFFF, 32'hFFFF0000};

    // Reset held for two edges.
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef EXT_ERR_EN
    check("rst_out_err", {31'b0, out_err}, 32'd0);
`endif

    // Single SIGN push with 1-cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 16'h8001);
    tick();
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_data", out_data, 32'hFFFF8001);
    drive(1'b0, 3'b000, 16'h0000);
    tick();
    check("single_gone", {31'b0, out_valid}, 32'd0);

    // Table, back-to-back one push per cycle, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].imm);
      cur_exp.data = vecs[i].exp;
      check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      check("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    end
    drain(8);

    // Back-pressure: A and B fill the buffer, C is held off.
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 16'h0001);
    tick();
    drive(1'b1, 3'b001, 16'hFFFF);
    check("bp_b_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp_full", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 3'b010, 16'h0001);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_head", out_data, 32'h00000001);
      check("bp_hold", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    // Buffer now holds B only; C pushes while B pops.
    check("pp_pre_ready", {31'b0, in_ready}, 32'd1);
    check("pp_pre_head", out_data, 32'h0000FFFF);
    tick();
    check("pp_count1", {31'b0, in_ready}, 32'd1);
    check("pp_valid", {31'b0, out_valid}, 32'd1);
    check("pp_head", out_data, 32'h00010000);
    drain(4);

    // in_valid low with changing inputs: nothing moves.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 16'($urandom));
      tick();
      check("idle_valid", {31'b0, out_valid}, 32'd0);
    end

    // Reset with two entries buffered flushes them.
    drive(1'b1, 3'b001, 16'h1111);
    tick();
    drive(1'b1, 3'b001, 16'h2222);
    tick();
    check("mrst_full", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 3'b000, 16'h0000);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb_q.delete();
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mrst_out_data", out_data, 32'h0);

    // Reserved mode at the head.
    drive(1'b1, 3'b101, 16'h1234);
    tick();
    drive(1'b0, 3'b000, 16'h0000);
    check("rsv_valid", {31'b0, out_valid}, 32'd1);
    check("rsv_data", out_data, 32'h0);
`ifdef EXT_ERR_EN
    check("rsv_err", {31'b0, out_err}, 32'd1);
`endif
    drain(4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
